cache_req_arbiter: RTL and testbench

Round-robin arbiter that shares the single CPU-side port of the cache core among `NUM_REQ` requesters, such as instruction fetch, load/store and debug. It accepts one request at a time and replays it onto the cache port (`valid_in_c`, `rw`, `addr`, `data_in`). It holds that transaction until the cache signals completion on `valid_out_c`, then routes `data_out` and `hit_miss` back to the owning requester. It sits between the requester ports and `cache_top`, and is the only driver of the cache CPU interface.

---
 rtl/cache_req_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_cache_req_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin arbiter sharing the cache CPU port
// among NUM_REQ requesters. One transaction is outstanding at a time.
// Ports: clk, rst (async, active-high); requester side req_valid/rw/
// addr/data in, req_ready/rsp_valid/rsp_data/rsp_hit/rsp_err out;
// cache side valid_in_c/rw/addr/data_in out, data_out/valid_out_c/
// hit_miss in.
// Optional macro CACHE_ARB_WATCHDOG_EN adds a timeout that aborts a
// stalled WAIT with rsp_err=1 after TIMEOUT_CYCLES cycles.
module cache_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_SIZE      = 32,
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_rw,
  input  logic [NUM_REQ-1:0][ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_SIZE-1:0]                rsp_data,
  output logic                                rsp_hit,
  output logic                                rsp_err,
  output logic                                valid_in_c,
  output logic                                rw,
  output logic [ADDR_SIZE-1:0]                addr,
  output logic [DATA_SIZE-1:0]                data_in,
  input  logic [DATA_SIZE-1:0]                data_out,
  input  logic                                valid_out_c,
  input  logic                                hit_miss
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic                  rw_q, rw_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [DATA_SIZE-1:0]  wdata_q, wdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_SIZE-1:0]  rsp_data_q, rsp_data_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  win_found;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         win_next;
  logic                  done;
  logic                  abort;
  int                    j;

  // First requesting index at or after rr_ptr, wrapping explicitly so
  // non-power-of-2 NUM_REQ works.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

  assign win_next = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);

  // Completion is accepted in ISSUE as well as WAIT; in IDLE it is spurious.
  assign done = valid_out_c && (state_q == ISSUE || state_q == WAIT);

`ifdef CACHE_ARB_WATCHDOG_EN
  logic [15:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (state_d == ISSUE) wd_d = '0;
    else if (state_q == WAIT) wd_d = wd_q + 16'd1;
  end

  // Limit is reached during this WAIT cycle; valid_out_c still wins.
  assign abort = (state_q == WAIT) && !valid_out_c &&
                 (wd_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign abort = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next state and next datapath values
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = ISSUE;
          owner_d  = win_idx;
          rw_d     = req_rw[win_idx];
          addr_d   = req_addr[win_idx];
          wdata_d  = req_data[win_idx];
          rr_ptr_d = win_next;
        end
      end
      ISSUE, WAIT: begin
        if (done) begin
          state_d     = IDLE;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_data_d  = data_out;
          rsp_hit_d   = hit_miss;
          rsp_err_d   = 1'b0;
        end else if (abort) begin
          state_d     = IDLE;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_data_d  = '0;
          rsp_hit_d   = 1'b0;
          rsp_err_d   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; req_ready is gated by rst so every output reads 0 in reset.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_found && !rst)
      req_ready = NUM_REQ'(1) << win_idx;
    valid_in_c = (state_q == ISSUE);
  end

  assign rw        = rw_q;
  assign addr      = addr_q;
  assign data_in   = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: directed self-checking bench for the cache
// request arbiter (4 requesters, TIMEOUT_CYCLES=16).
module tb_cache_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_rw;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_hit;
  logic                 rsp_err;
  logic                 valid_in_c;
  logic                 rw;
  logic [AW-1:0]        addr;
  logic [DW-1:0]        data_in;
  logic [DW-1:0]        data_out;
  logic                 valid_out_c;
  logic                 hit_miss;

  int n_cmp = 0;
  int n_err = 0;

  cache_req_arbiter #(
    .NUM_REQ(N), .ADDR_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .valid_in_c(valid_in_c), .rw(rw), .addr(addr), .data_in(data_in),
    .data_out(data_out), .valid_out_c(valid_out_c), .hit_miss(hit_miss)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    req_valid   = '0;
    req_rw      = '0;
    req_addr    = '0;
    req_data    = '0;
    valid_out_c = 1'b0;
    data_out    = '0;
    hit_miss    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready);
    end
    n_cmp++;
    if (rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid);
    end
    n_cmp++;
    if ({valid_in_c, rw, addr, data_in} !== '0) begin
      n_err++;
      $display("FAIL reset_cache_side got %b %b %h %h want all 0",
               valid_in_c, rw, addr, data_in);
    end
    n_cmp++;
    if ({rsp_data, rsp_hit, rsp_err} !== '0) begin
      n_err++;
      $display("FAIL reset_rsp got %h %b %b want all 0",
               rsp_data, rsp_hit, rsp_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    req_valid   = 4'b0100;
    req_rw[2]   = 1'b0;
    req_addr[2] = 32'h0000_1040;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL rd_grant got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_cmp++;
    if ({valid_in_c, rw, addr} !== {1'b1, 1'b0, 32'h0000_1040}) begin
      n_err++;
      $display("FAIL rd_issue got v=%b rw=%b a=%h want v=1 rw=0 a=00001040",
               valid_in_c, rw, addr);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (valid_in_c !== 1'b0) begin
      n_err++; $display("FAIL rd_issue_pulse got %b want 0", valid_in_c);
    end
    @(negedge clk);
    @(negedge clk);
    valid_out_c = 1'b1;
    data_out    = 32'hDEAD_BEEF;
    hit_miss    = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL rd_rsp_early got %b want 0000", rsp_valid);
    end
    @(negedge clk);
    valid_out_c = 1'b0;
    data_out    = '0;
    hit_miss    = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_data, rsp_hit, rsp_err} !==
        {4'b0100, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL rd_rsp got %b %h %b %b want 0100 deadbeef 1 0",
               rsp_valid, rsp_data, rsp_hit, rsp_err);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL rd_rsp_pulse got %b want 0000", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i] = 32'h100 * (i + 1);
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (req_ready !== 4'(1 << order[k])) begin
        n_err++;
        $display("FAIL rr_grant%0d got %b want %b",
                 k, req_ready, 4'(1 << order[k]));
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({valid_in_c, addr} !== {1'b1, 32'h100 * (order[k] + 1)}) begin
        n_err++;
        $display("FAIL rr_issue%0d got v=%b a=%h want v=1 a=%h",
                 k, valid_in_c, addr, 32'h100 * (order[k] + 1));
      end
      valid_out_c = 1'b1;
      data_out    = 32'(k);
      @(negedge clk);
      valid_out_c = 1'b0;
      #1;
      n_cmp++;
      if (rsp_valid !== 4'(1 << order[k])) begin
        n_err++;
        $display("FAIL rr_rsp%0d got %b want %b",
                 k, rsp_valid, 4'(1 << order[k]));
      end
    end
    req_valid = '0;
  endtask

  task automatic test_hold_miss();
    int bad = 0;
    do_reset();
    @(negedge clk);
    req_valid   = 4'b0010;
    req_rw[1]   = 1'b1;
    req_addr[1] = 32'h0000_2000;
    req_data[1] = 32'hCAFE_0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL hold_grant got %b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid   = 4'b0001;
    req_rw[0]   = 1'b0;
    req_addr[0] = 32'h0000_3000;
    #1;
    n_cmp++;
    if ({valid_in_c, req_ready, rw, addr, data_in} !==
        {1'b1, 4'b0000, 1'b1, 32'h0000_2000, 32'hCAFE_0001}) begin
      n_err++;
      $display("FAIL hold_issue got v=%b rdy=%b rw=%b a=%h d=%h",
               valid_in_c, req_ready, rw, addr, data_in);
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 40) begin
        valid_out_c = 1'b1;
        data_out    = 32'h0;
      end
      #1;
      if ({rw, addr, data_in} !== {1'b1, 32'h0000_2000, 32'hCAFE_0001} ||
          req_ready !== 4'b0000 || valid_in_c !== 1'b0 ||
          rsp_valid !== 4'b0000)
        bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL hold_stable got %0d bad cycles want 0", bad);
    end
    @(negedge clk);
    valid_out_c = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, req_ready, rsp_err} !== {4'b0010, 4'b0001, 1'b0}) begin
      n_err++;
      $display("FAIL hold_rsp_grant got rsp=%b rdy=%b err=%b want 0010 0001 0",
               rsp_valid, req_ready, rsp_err);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_cmp++;
    if ({valid_in_c, addr} !== {1'b1, 32'h0000_3000}) begin
      n_err++;
      $display("FAIL hold_next_issue got v=%b a=%h want v=1 a=00003000",
               valid_in_c, addr);
    end
    valid_out_c = 1'b1;
    @(negedge clk);
    valid_out_c = 1'b0;
  endtask

  task automatic test_spurious_early();
    do_reset();
    @(negedge clk);
    valid_out_c = 1'b1;
    data_out    = 32'hFFFF_FFFF;
    hit_miss    = 1'b1;
    @(negedge clk);
    valid_out_c = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_hit, rsp_data} !== '0) begin
      n_err++;
      $display("FAIL spurious got rsp=%b hit=%b d=%h want all 0",
               rsp_valid, rsp_hit, rsp_data);
    end
    @(negedge clk);
    req_valid   = 4'b1000;
    req_addr[3] = 32'h0000_4440;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_err++; $display("FAIL early_grant got %b want 1000", req_ready);
    end
    @(negedge clk);
    req_valid   = '0;
    valid_out_c = 1'b1;
    data_out    = 32'h1234_5678;
    hit_miss    = 1'b0;
    @(negedge clk);
    valid_out_c = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_data, rsp_hit, rsp_err, valid_in_c} !==
        {4'b1000, 32'h1234_5678, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL early_rsp got %b %h %b %b v=%b want 1000 12345678 0 0 v=0",
               rsp_valid, rsp_data, rsp_hit, rsp_err, valid_in_c);
    end
  endtask

`ifdef CACHE_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int bad = 0;
    do_reset();
    @(negedge clk);
    req_valid   = 4'b0001;
    req_addr[0] = 32'h0000_5000;
    @(negedge clk);
    req_valid   = '0;
    valid_out_c = 1'b1;
    data_out    = 32'h5555_AAAA;
    hit_miss    = 1'b1;
    @(negedge clk);
    valid_out_c = 1'b0;
    req_valid   = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    #1;
    n_cmp++;
    if (valid_in_c !== 1'b1) begin
      n_err++; $display("FAIL wd_issue got %b want 1", valid_in_c);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 4'b0000) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL wd_quiet got %0d early responses want 0", bad);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_data, rsp_hit} !==
        {4'b0001, 1'b1, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL wd_abort got %b err=%b %h %b want 0001 err=1 0 0",
               rsp_valid, rsp_err, rsp_data, rsp_hit);
    end
    @(negedge clk);
    valid_out_c = 1'b1;
    data_out    = 32'hAAAA_AAAA;
    @(negedge clk);
    valid_out_c = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL wd_late got %b want 0000", rsp_valid);
    end
  endtask
`else
  task automatic test_no_watchdog();
    int bad = 0;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 4'b0000 || rsp_err !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL nowd_wait got %0d bad cycles want 0", bad);
    end
    valid_out_c = 1'b1;
    data_out    = 32'h0BAD_F00D;
    @(negedge clk);
    valid_out_c = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_data} !==
        {4'b0001, 1'b0, 32'h0BAD_F00D}) begin
      n_err++;
      $display("FAIL nowd_rsp got %b err=%b %h want 0001 err=0 0badf00d",
               rsp_valid, rsp_err, rsp_data);
    end
  endtask
`endif

  task automatic test_reset_mid_wait();
    int bad = 0;
    do_reset();
    @(negedge clk);
    req_valid   = 4'b0100;
    req_rw[2]   = 1'b1;
    req_addr[2] = 32'h0000_6000;
    req_data[2] = 32'h0000_0077;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({valid_in_c, addr} !== {1'b0, 32'h0000_6000}) begin
      n_err++;
      $display("FAIL rstw_wait got v=%b a=%h want v=0 a=00006000",
               valid_in_c, addr);
    end
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, valid_in_c, rw, addr, data_in,
         rsp_data, rsp_hit, rsp_err} !== '0) begin
      n_err++;
      $display("FAIL rstw_async got rdy=%b rsp=%b v=%b rw=%b a=%h d=%h",
               req_ready, rsp_valid, valid_in_c, rw, addr, data_in);
    end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 4'b0000 || valid_in_c !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL rstw_no_rsp got %0d bad cycles want 0", bad);
    end
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL rstw_ptr got %b want 0001", req_ready);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_hold_miss();
    test_spurious_early();
`ifdef CACHE_ARB_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
